ai_i2s_rx_multich: RTL and testbench

//  Multi-channel I2S/left-justified/TDM receive path: frames sd against ws, deserialises each slot MSB-first,

---
 rtl/ai_i2s_pkg.sv | 21 ++
 rtl/ai_i2s_rx_fifo_sr.sv | 70 +++++++
 rtl/ai_i2s_rx_multich.sv | 230 +++++++++++++++++++++++
 tb/tb_ai_i2s_rx_multich.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ai_i2s_pkg.sv
// Shared types for the multi-channel I2S/LJ/TDM receive path.
package ai_i2s_pkg;

  typedef enum logic [1:0] {
    FMT_I2S  = 2'd0,
    FMT_LJ   = 2'd1,
    FMT_TDM  = 2'd2,
    FMT_RSVD = 2'd3
  } fmt_e;

  typedef enum logic [2:0] {
    IDLE,
    SYNC,
    DELAY,
    SHIFT,
    WAIT_FRAME
  } rx_state_e;

  localparam int MIN_RES = 16;

endpackage

// File: rtl/ai_i2s_rx_fifo_sr.sv
// Synchronous FIFO for {ch,data} words; registered read port and registered status/level.
module ai_i2s_rx_fifo_sr #(
  parameter int WIDTH = 35,
  parameter int DEPTH = 16,
  parameter int LW    = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             rd_valid,
  output logic             empty,
  output logic             full,
  output logic [LW-1:0]    level
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wp_q, rp_q;
  logic [LW-1:0]    level_q, level_d;
  logic             empty_q, full_q, rd_valid_q;
  logic [WIDTH-1:0] rd_data_q;
  logic             do_wr, do_rd;

  // A pop frees a slot in the same cycle, so a full FIFO still accepts a write alongside a read.
  assign do_wr = wr_en && (!full_q || rd_en);
  assign do_rd = rd_en && !empty_q;

  always_comb begin
    level_d = level_q;
    if (do_wr && !do_rd) level_d = level_q + LW'(1);
    else if (!do_wr && do_rd) level_d = level_q - LW'(1);
  end

  always_ff @(posedge clk) begin
    if (do_wr) mem_q[wp_q] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wp_q       <= '0;
      rp_q       <= '0;
      level_q    <= '0;
      empty_q    <= 1'b1;
      full_q     <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      if (do_wr) wp_q <= wp_q + AW'(1);
      if (do_rd) begin
        rp_q      <= rp_q + AW'(1);
        rd_data_q <= mem_q[rp_q];
      end
      rd_valid_q <= do_rd;
      level_q    <= level_d;
      empty_q    <= (level_d == '0);
      full_q     <= (level_d == LW'(DEPTH));
    end
  end

  assign rd_data  = rd_data_q;
  assign rd_valid = rd_valid_q;
  assign empty    = empty_q;
  assign full     = full_q;
  assign level    = level_q;

endmodule

// File: rtl/ai_i2s_rx_multich.sv
// Multi-channel I2S / left-justified / TDM receiver: frames sd against ws, deserialises
// MSB-first, sign-extends and queues {ch,data} words for the register interface.
module ai_i2s_rx_multich
  import ai_i2s_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_CH     = 2,
  parameter int FIFO_DEPTH = 16,
  parameter int CH_W       = $clog2(NUM_CH)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          rx_en,
  input  logic [1:0]                    fmt,
  input  logic [5:0]                    resolution,
  input  logic                          tswap,
  input  logic                          clk_en,
  input  logic                          ws,
  input  logic                          sd,
  input  logic                          rd_en,
  output logic [DATA_WIDTH-1:0]         rd_data,
  output logic [CH_W-1:0]               rd_ch,
  output logic                          rd_valid,
  output logic                          fifo_empty,
  output logic                          fifo_full,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          overflow,
  output logic                          frame_err,
  input  logic                          err_clr
);

  localparam logic [5:0]      SLOT_LAST = 6'(DATA_WIDTH - 1);
  localparam logic [CH_W-1:0] CH_LAST   = CH_W'(NUM_CH - 1);

  rx_state_e             state_q, state_d;
  logic                  ws_q;
  logic [DATA_WIDTH-1:0] acc_q, acc_d, acc_sh;
  logic [5:0]            cnt_q, cnt_d, pos_q, pos_d, res_q, res_d, res_in;
  logic [CH_W-1:0]       ch_q, ch_d, tag_q, tag_d;
  logic                  push_q, push_d;
  logic [DATA_WIDTH-1:0] word_q, word_d;
  logic                  overflow_q, frame_err_q, ferr_set, ovf_set;
  logic                  ws_rise, ws_fall, ws_edge, start, tdm;
  fmt_e                  fmt_eff;
  logic                  ff_full;

  function automatic logic [DATA_WIDTH-1:0] sext(input logic [DATA_WIDTH-1:0] v,
                                                 input logic [5:0] n);
    logic [DATA_WIDTH-1:0] r;
    logic s;
    r = '0;
    s = 1'b0;
    for (int i = 0; i < DATA_WIDTH; i++) if (i == int'(n) - 1) s = v[i];
    for (int i = 0; i < DATA_WIDTH; i++) r[i] = (i < int'(n)) ? v[i] : s;
    return r;
  endfunction

  assign fmt_eff = (fmt_e'(fmt) == FMT_RSVD) ? FMT_I2S : fmt_e'(fmt);
  assign tdm     = (fmt_eff == FMT_TDM);
  assign res_in  = (resolution < 6'(MIN_RES) || int'(resolution) > DATA_WIDTH)
                   ? 6'(MIN_RES) : resolution;
  assign ws_rise = clk_en && ws && !ws_q;
  assign ws_fall = clk_en && !ws && ws_q;
  assign ws_edge = ws_rise || ws_fall;
  assign start   = tdm ? ws_rise : ws_fall;
  assign acc_sh  = (acc_q << 1) | DATA_WIDTH'(sd);

  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    pos_d    = pos_q;
    ch_d     = ch_q;
    res_d    = res_q;
    push_d   = 1'b0;
    word_d   = word_q;
    tag_d    = tag_q;
    ferr_set = 1'b0;
    if (!rx_en) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: state_d = SYNC;
        SYNC, WAIT_FRAME: begin
          if (start) begin
            ch_d  = '0;
            res_d = res_in;
            pos_d = 6'd1;
            if (fmt_eff == FMT_I2S) begin
              state_d = DELAY;
              acc_d   = '0;
              cnt_d   = '0;
            end else begin
              state_d = SHIFT;
              acc_d   = DATA_WIDTH'(sd);
              cnt_d   = 6'd1;
            end
          end
        end
        DELAY: begin
          if (clk_en) begin
            state_d = SHIFT;
            acc_d   = DATA_WIDTH'(sd);
            cnt_d   = 6'd1;
          end
        end
        SHIFT: begin
          if (clk_en) begin
            if (tdm) begin
              if (ws_rise) begin
                ferr_set = 1'b1;
                ch_d     = '0;
                res_d    = res_in;
                acc_d    = DATA_WIDTH'(sd);
                cnt_d    = 6'd1;
                pos_d    = 6'd1;
              end else begin
                if (cnt_q < res_q) begin
                  acc_d = acc_sh;
                  cnt_d = cnt_q + 6'd1;
                  if (cnt_q + 6'd1 == res_q) begin
                    push_d = 1'b1;
                    word_d = sext(acc_sh, res_q);
                    tag_d  = ch_q;
                  end
                end
                if (pos_q == SLOT_LAST) begin
                  if (ch_q == CH_LAST) begin
                    state_d = WAIT_FRAME;
                  end else begin
                    ch_d  = ch_q + CH_W'(1);
                    pos_d = '0;
                    cnt_d = '0;
                    acc_d = '0;
                    res_d = res_in;
                  end
                end else begin
                  pos_d = pos_q + 6'd1;
                end
              end
            end else if (ws_edge) begin
              // I2S: the edge bit is still the previous slot's LSB; LJ: it is the new slot's MSB.
              if (fmt_eff == FMT_I2S) begin
                if (cnt_q < res_q) begin
                  if (cnt_q + 6'd1 == res_q) begin
                    push_d = 1'b1;
                    word_d = sext(acc_sh, res_q);
                    tag_d  = ch_q ^ CH_W'(tswap);
                  end else begin
                    ferr_set = 1'b1;
                  end
                end
                state_d = DELAY;
              end else begin
                if (cnt_q < res_q) ferr_set = 1'b1;
                acc_d = DATA_WIDTH'(sd);
                cnt_d = 6'd1;
              end
              ch_d  = CH_W'(ws);
              res_d = res_in;
            end else if (cnt_q < res_q) begin
              acc_d = acc_sh;
              cnt_d = cnt_q + 6'd1;
              if (cnt_q + 6'd1 == res_q) begin
                push_d = 1'b1;
                word_d = sext(acc_sh, res_q);
                tag_d  = ch_q ^ CH_W'(tswap);
              end
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign ovf_set = push_q && ff_full && !rd_en;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      ws_q        <= 1'b0;
      acc_q       <= '0;
      cnt_q       <= '0;
      pos_q       <= '0;
      ch_q        <= '0;
      res_q       <= 6'(MIN_RES);
      push_q      <= 1'b0;
      word_q      <= '0;
      tag_q       <= '0;
      overflow_q  <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      if (clk_en) ws_q <= ws;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      pos_q       <= pos_d;
      ch_q        <= ch_d;
      res_q       <= res_d;
      push_q      <= push_d;
      word_q      <= word_d;
      tag_q       <= tag_d;
      overflow_q  <= ovf_set || (overflow_q && !err_clr);
      frame_err_q <= ferr_set || (frame_err_q && !err_clr);
    end
  end

  ai_i2s_rx_fifo_sr #(
    .WIDTH (DATA_WIDTH + CH_W),
    .DEPTH (FIFO_DEPTH),
    .LW    ($clog2(FIFO_DEPTH) + 1)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (push_q),
    .wr_data  ({tag_q, word_q}),
    .rd_en    (rd_en),
    .rd_data  ({rd_ch, rd_data}),
    .rd_valid (rd_valid),
    .empty    (fifo_empty),
    .full     (ff_full),
    .level    (fifo_level)
  );

  assign fifo_full = ff_full;
  assign overflow  = overflow_q;
  assign frame_err = frame_err_q;

endmodule

// File: tb/tb_ai_i2s_rx_multich.sv
// Directed bench for ai_i2s_rx_multich: stereo vector table plus TDM, overflow, framing and reset sequences.
module tb_ai_i2s_rx_multich;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        rx_en = 1'b0;
  logic [1:0]  fmt = 2'd0;
  logic [5:0]  resolution = 6'd24;
  logic        tswap = 1'b0;
  logic        clk_en = 1'b0;
  logic        ws = 1'b0;
  logic        sd = 1'b0;
  logic        rd_en = 1'b0;
  logic        err_clr = 1'b0;
  logic [31:0] rd_data;
  logic [2:0]  rd_ch;
  logic        rd_valid, fifo_empty, fifo_full, overflow, frame_err;
  logic [4:0]  fifo_level;

  int nvec = 0;
  int nfail = 0;

  always #5 clk = ~clk;

  ai_i2s_rx_multich #(.DATA_WIDTH(32), .NUM_CH(8), .FIFO_DEPTH(16)) dut (
    .clk(clk), .rst(rst), .rx_en(rx_en), .fmt(fmt), .resolution(resolution), .tswap(tswap),
    .clk_en(clk_en), .ws(ws), .sd(sd), .rd_en(rd_en), .rd_data(rd_data), .rd_ch(rd_ch),
    .rd_valid(rd_valid), .fifo_empty(fifo_empty), .fifo_full(fifo_full), .fifo_level(fifo_level),
    .overflow(overflow), .frame_err(frame_err), .err_clr(err_clr)
  );

  typedef struct {
    logic [1:0]  fmt;
    logic [5:0]  res_cfg;
    int          res_wave;
    int          delay;
    logic        tswap;
    logic [31:0] wl, wr, e0;
    logic [2:0]  c0;
    logic [31:0] e1;
    logic [2:0]  c1;
  } vec_t;

  vec_t vt[9];

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic bit_out(input logic w, input logic d);
    @(negedge clk);
    ws = w; sd = d; clk_en = 1'b1;
    @(negedge clk);
    clk_en = 1'b0;
  endtask

  task automatic send_slot(input logic w, input logic [31:0] word, input int res, input int delay);
    for (int j = 0; j < 32; j++) begin
      int k;
      k = j - delay;
      if (k >= 0 && k < res) bit_out(w, word[res-1-k]);
      else bit_out(w, 1'b0);
    end
  endtask

  task automatic send_tdm_slot(input logic pulse, input logic [31:0] word);
    for (int j = 0; j < 32; j++) bit_out((j == 0) ? pulse : 1'b0, word[31-j]);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; rx_en = 1'b0; rd_en = 1'b0; err_clr = 1'b0;
    idle(2);
    rst = 1'b0;
  endtask

  task automatic pop_check(input string nm, input logic [31:0] ed, input logic [2:0] ec);
    @(negedge clk);
    rd_en = 1'b1;
    @(negedge clk);
    rd_en = 1'b0;
    check({nm, " valid"}, 64'(rd_valid), 64'd1);
    check({nm, " data"}, 64'(rd_data), 64'(ed));
    check({nm, " ch"}, 64'(rd_ch), 64'(ec));
  endtask

  task automatic clear_errs();
    @(negedge clk);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // fmt, res_cfg, res_wave, delay, tswap, L, R, exp0, ch0, exp1, ch1
    vt[0] = '{2'd0, 6'd24, 24, 1, 1'b0, 32'h800001, 32'h123456, 32'hFF800001, 3'd0, 32'h00123456, 3'd1};
    vt[1] = '{2'd1, 6'd24, 24, 0, 1'b1, 32'h800001, 32'h123456, 32'hFF800001, 3'd1, 32'h00123456, 3'd0};
    vt[2] = '{2'd0, 6'd24, 24, 0, 1'b0, 32'h800001, 32'h123456, 32'h00000002, 3'd0, 32'h002468AC, 3'd1};
    vt[3] = '{2'd1, 6'd16, 16, 0, 1'b0, 32'h8000, 32'h7FFF, 32'hFFFF8000, 3'd0, 32'h00007FFF, 3'd1};
    vt[4] = '{2'd1, 6'd32, 32, 0, 1'b0, 32'hDEADBEEF, 32'h1, 32'hDEADBEEF, 3'd0, 32'h00000001, 3'd1};
    vt[5] = '{2'd0, 6'd20, 20, 1, 1'b0, 32'hFFFFF, 32'h80000, 32'hFFFFFFFF, 3'd0, 32'hFFF80000, 3'd1};
    vt[6] = '{2'd0, 6'd8, 16, 1, 1'b0, 32'hABCD, 32'h1234, 32'hFFFFABCD, 3'd0, 32'h00001234, 3'd1};
    vt[7] = '{2'd3, 6'd24, 24, 1, 1'b0, 32'h1, 32'hFFFFFF, 32'h00000001, 3'd0, 32'hFFFFFFFF, 3'd1};
    vt[8] = '{2'd1, 6'd40, 16, 0, 1'b0, 32'h1, 32'hFFFE, 32'h00000001, 3'd0, 32'hFFFFFFFE, 3'd1};

    do_reset();
    idle(1);
    check("rst empty", 64'(fifo_empty), 64'd1);
    check("rst full", 64'(fifo_full), 64'd0);
    check("rst level", 64'(fifo_level), 64'd0);
    check("rst valid", 64'(rd_valid), 64'd0);
    check("rst data", 64'(rd_data), 64'd0);
    check("rst ch", 64'(rd_ch), 64'd0);
    check("rst overflow", 64'(overflow), 64'd0);
    check("rst frame_err", 64'(frame_err), 64'd0);

    for (int i = 0; i < 9; i++) begin
      do_reset();
      fmt = vt[i].fmt; resolution = vt[i].res_cfg; tswap = vt[i].tswap;
      @(negedge clk);
      rx_en = 1'b1;
      bit_out(1'b1, 1'b0);
      bit_out(1'b1, 1'b0);
      send_slot(1'b0, vt[i].wl, vt[i].res_wave, vt[i].delay);
      send_slot(1'b1, vt[i].wr, vt[i].res_wave, vt[i].delay);
      bit_out(1'b0, 1'b0);
      rx_en = 1'b0;
      idle(4);
      check($sformatf("v%0d level", i), 64'(fifo_level), 64'd2);
      pop_check($sformatf("v%0d first", i), vt[i].e0, vt[i].c0);
      pop_check($sformatf("v%0d second", i), vt[i].e1, vt[i].c1);
      idle(1);
      check($sformatf("v%0d empty", i), 64'(fifo_empty), 64'd1);
      check($sformatf("v%0d frame_err", i), 64'(frame_err), 64'd0);
    end
    tswap = 1'b0;

    // TDM: clean 8-slot frame, then a frame broken by a ws pulse at slot 3
    do_reset();
    fmt = 2'd2; resolution = 6'd32;
    @(negedge clk);
    rx_en = 1'b1;
    bit_out(1'b0, 1'b0);
    for (int s = 0; s < 8; s++) send_tdm_slot(s == 0, 32'(s));
    idle(4);
    check("tdm level", 64'(fifo_level), 64'd8);
    for (int s = 0; s < 8; s++) pop_check($sformatf("tdm slot%0d", s), 32'(s), 3'(s));
    check("tdm frame_err clean", 64'(frame_err), 64'd0);
    for (int s = 0; s < 3; s++) send_tdm_slot(s == 0, 32'h10 + 32'(s));
    for (int s = 0; s < 8; s++) send_tdm_slot(s == 0, 32'h20 + 32'(s));
    idle(4);
    check("tdm early pulse frame_err", 64'(frame_err), 64'd1);
    check("tdm resync level", 64'(fifo_level), 64'd11);
    for (int s = 0; s < 3; s++) pop_check($sformatf("tdm part%0d", s), 32'h10 + 32'(s), 3'(s));
    for (int s = 0; s < 8; s++) pop_check($sformatf("tdm resync%0d", s), 32'h20 + 32'(s), 3'(s));
    rx_en = 1'b0;

    // 17 words into a 16-deep FIFO with no reads
    do_reset();
    fmt = 2'd1; resolution = 6'd16;
    @(negedge clk);
    rx_en = 1'b1;
    bit_out(1'b1, 1'b0);
    bit_out(1'b1, 1'b0);
    for (int s = 0; s < 17; s++) send_slot(1'(s % 2), 32'h1000 + 32'(s), 16, 0);
    bit_out(1'b1, 1'b0);
    rx_en = 1'b0;
    idle(4);
    check("ovf full", 64'(fifo_full), 64'd1);
    check("ovf level", 64'(fifo_level), 64'd16);
    check("ovf overflow", 64'(overflow), 64'd1);
    for (int s = 0; s < 16; s++) pop_check($sformatf("ovf word%0d", s), 32'h1000 + 32'(s), 3'(s % 2));
    idle(1);
    check("ovf drained empty", 64'(fifo_empty), 64'd1);
    check("ovf sticky", 64'(overflow), 64'd1);
    clear_errs();
    check("ovf cleared", 64'(overflow), 64'd0);

    // I2S res 16: ws toggles after 10 data bits, next slot still lands normally
    do_reset();
    fmt = 2'd0; resolution = 6'd16;
    @(negedge clk);
    rx_en = 1'b1;
    bit_out(1'b1, 1'b0);
    bit_out(1'b1, 1'b0);
    for (int j = 0; j < 11; j++) bit_out(1'b0, 1'b1);
    idle(3);
    check("short frame_err", 64'(frame_err), 64'd0);
    send_slot(1'b1, 32'h1234, 16, 1);
    bit_out(1'b0, 1'b0);
    idle(4);
    check("short frame_err set", 64'(frame_err), 64'd1);
    check("short level", 64'(fifo_level), 64'd1);
    pop_check("short next slot", 32'h00001234, 3'd1);
    clear_errs();
    check("short cleared", 64'(frame_err), 64'd0);

    // rx_en dropped mid-word, re-enabled mid-frame: only the next full frame counts
    @(negedge clk);
    rx_en = 1'b0;
    idle(2);
    rx_en = 1'b1;
    bit_out(1'b1, 1'b0);
    bit_out(1'b1, 1'b0);
    bit_out(1'b0, 1'b0);
    for (int j = 0; j < 10; j++) bit_out(1'b0, 1'b1);
    rx_en = 1'b0;
    idle(2);
    rx_en = 1'b1;
    for (int j = 0; j < 21; j++) bit_out(1'b0, 1'b1);
    idle(3);
    check("rxen drop level", 64'(fifo_level), 64'd0);
    send_slot(1'b1, 32'h5555, 16, 1);
    send_slot(1'b0, 32'h0A0A, 16, 1);
    bit_out(1'b1, 1'b0);
    rx_en = 1'b0;
    idle(4);
    check("rxen resync level", 64'(fifo_level), 64'd1);
    pop_check("rxen resync word", 32'h00000A0A, 3'd0);
    check("rxen frame_err", 64'(frame_err), 64'd0);

    // reset mid-frame with 3 queued words and a pop in flight
    do_reset();
    fmt = 2'd1; resolution = 6'd16;
    @(negedge clk);
    rx_en = 1'b1;
    bit_out(1'b1, 1'b0);
    bit_out(1'b1, 1'b0);
    send_slot(1'b0, 32'h0111, 16, 0);
    send_slot(1'b1, 32'h0222, 16, 0);
    send_slot(1'b0, 32'h0333, 16, 0);
    for (int j = 0; j < 10; j++) bit_out(1'b1, 1'b1);
    idle(3);
    check("mid rst level before", 64'(fifo_level), 64'd3);
    @(negedge clk);
    rd_en = 1'b1;
    @(negedge clk);
    rd_en = 1'b0;
    check("mid rst pop valid", 64'(rd_valid), 64'd1);
    check("mid rst pop data", 64'(rd_data), 64'h0111);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mid rst empty", 64'(fifo_empty), 64'd1);
    check("mid rst level", 64'(fifo_level), 64'd0);
    check("mid rst valid", 64'(rd_valid), 64'd0);
    for (int j = 0; j < 22; j++) bit_out(1'b1, 1'b1);
    send_slot(1'b0, 32'h2222, 16, 0);
    bit_out(1'b1, 1'b0);
    rx_en = 1'b0;
    idle(4);
    check("mid rst resync level", 64'(fifo_level), 64'd1);
    pop_check("mid rst resync word", 32'h00002222, 3'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
